// File: rtl/upsample_patch_fetcher.sv
// Sweeps a 4x4 window across one filtered row: the first window is fetched in
// full, every later step shifts left and fetches only the new right column.
// state   | meaning
// IDLE    | waiting for start_in
// FILL    | issuing one registered read per cycle, slots k..15
// WAIT    | all reads issued, collecting outstanding returns
// PRESENT | patch_out valid, waiting for patch_ready_in
// DRAIN   | aborted fetch, discarding in-flight returns
module upsample_patch_fetcher #(
  parameter int FILTERED_WIDTH = 131,
  parameter int OUT_COLS       = 128,
  parameter int READ_LATENCY   = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         frame_rst_in,
  input  logic         start_in,
  input  logic [9:0]   patch_row_in,
  output logic         valid_read_out,
  output logic [10:0]  read_hor_addr_out,
  output logic [9:0]   read_ver_addr_out,
  input  logic [15:0]  pixel_read_in,
  input  logic         pixel_valid_in,
  output logic [255:0] patch_out,
  output logic         patch_valid_out,
  input  logic         patch_ready_in,
  output logic [6:0]   patch_x_out,
  output logic [9:0]   patch_y_out,
  output logic         busy_out,
  output logic         row_done_out
);

  localparam int LAST_COL = (OUT_COLS < FILTERED_WIDTH - 3) ? OUT_COLS - 1 : FILTERED_WIDTH - 4;
  localparam logic [6:0] LAST_X = 7'(LAST_COL);
  localparam int DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, FILL, WAIT, PRESENT, DRAIN} state_t;

  state_t          state_q;
  logic [9:0]      row_q;
  logic [6:0]      x_q;
  logic [3:0]      k_q;
  logic [3:0]      j_q;
  logic            ret_done_q;
  logic [DW-1:0]   drain_q;
  logic [255:0]    patch_q;
  logic            valid_read_q;
  logic [10:0]     hor_q;
  logic [9:0]      ver_q;
  logic            patch_valid_q;
  logic            row_done_q;

  logic [10:0]     hor_d;
  logic [9:0]      ver_d;
  logic [7:0]      wr_idx_d;
  logic            capture_d;

  assign hor_d    = {4'b0, x_q} + {9'b0, k_q[3:2]};
  assign ver_d    = row_q + {8'b0, k_q[1:0]};
  // return slot j lands at row j[1:0], column j[3:2]
  assign wr_idx_d = {j_q[1:0], j_q[3:2], 4'b0000};
  assign capture_d = (state_q == FILL || state_q == WAIT) && pixel_valid_in &&
                     !ret_done_q && !frame_rst_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      row_q         <= '0;
      x_q           <= '0;
      k_q           <= '0;
      j_q           <= '0;
      ret_done_q    <= 1'b0;
      drain_q       <= '0;
      patch_q       <= '0;
      valid_read_q  <= 1'b0;
      hor_q         <= '0;
      ver_q         <= '0;
      patch_valid_q <= 1'b0;
      row_done_q    <= 1'b0;
    end else begin
      valid_read_q <= 1'b0;
      row_done_q   <= 1'b0;
      if (capture_d) begin
        patch_q[wr_idx_d +: 16] <= pixel_read_in;
        j_q <= j_q + 4'd1;
        if (j_q == 4'd15) ret_done_q <= 1'b1;
      end
      if (frame_rst_in) begin
        patch_valid_q <= 1'b0;
        drain_q       <= DRAIN_LOAD;
        state_q       <= (state_q == FILL || state_q == WAIT) ? DRAIN : IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_in) begin
              row_q      <= patch_row_in;
              x_q        <= '0;
              k_q        <= '0;
              j_q        <= '0;
              ret_done_q <= 1'b0;
              state_q    <= FILL;
            end
          end
          FILL: begin
            valid_read_q <= 1'b1;
            hor_q        <= hor_d;
            ver_q        <= ver_d;
            k_q          <= k_q + 4'd1;
            if (k_q == 4'd15) state_q <= WAIT;
          end
          WAIT: begin
            if (ret_done_q) begin
              patch_valid_q <= 1'b1;
              state_q       <= PRESENT;
            end
          end
          PRESENT: begin
            if (patch_ready_in) begin
              patch_valid_q <= 1'b0;
              if (x_q == LAST_X) begin
                row_done_q <= 1'b1;
                state_q    <= IDLE;
              end else begin
                for (int r = 0; r < 4; r++) begin
                  for (int c = 0; c < 3; c++) begin
                    patch_q[(4*r+c)*16 +: 16] <= patch_q[(4*r+c+1)*16 +: 16];
                  end
                end
                x_q        <= x_q + 7'd1;
                k_q        <= 4'd12;
                j_q        <= 4'd12;
                ret_done_q <= 1'b0;
                state_q    <= FILL;
              end
            end
          end
          DRAIN: begin
            if (drain_q == '0) state_q <= IDLE;
            else drain_q <= drain_q - DW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign valid_read_out    = valid_read_q;
  assign read_hor_addr_out = hor_q;
  assign read_ver_addr_out = ver_q;
  assign patch_out         = patch_q;
  assign patch_valid_out   = patch_valid_q;
  assign patch_x_out       = x_q;
  assign patch_y_out       = row_q;
  assign busy_out          = (state_q != IDLE);
  assign row_done_out      = row_done_q;

endmodule

// File: tb/tb_upsample_patch_fetcher.sv
// Bench for upsample_patch_fetcher: filtered-buffer model returning
// (row<<8)|col two cycles after each read, with a scoreboard of expected patches.
module tb_upsample_patch_fetcher;

  localparam int LAST_X = 127;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic         frame_rst_in = 1'b0;
  logic         start_in = 1'b0;
  logic [9:0]   patch_row_in = '0;
  logic         valid_read_out;
  logic [10:0]  read_hor_addr_out;
  logic [9:0]   read_ver_addr_out;
  logic [15:0]  pixel_read_in = '0;
  logic         pixel_valid_in = 1'b0;
  logic [255:0] patch_out;
  logic         patch_valid_out;
  logic         patch_ready_in = 1'b0;
  logic [6:0]   patch_x_out;
  logic [9:0]   patch_y_out;
  logic         busy_out;
  logic         row_done_out;

  logic         inj_valid = 1'b0;
  logic [15:0]  inj_data = '0;

  int checks = 0;
  int failures = 0;
  int reads_full = 0;

  typedef struct {
    logic [255:0] data;
    logic [6:0]   x;
    logic [9:0]   y;
  } exp_t;
  exp_t sb[$];

  upsample_patch_fetcher #(.FILTERED_WIDTH(131), .OUT_COLS(128), .READ_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_rst_in(frame_rst_in), .start_in(start_in),
    .patch_row_in(patch_row_in), .valid_read_out(valid_read_out),
    .read_hor_addr_out(read_hor_addr_out), .read_ver_addr_out(read_ver_addr_out),
    .pixel_read_in(pixel_read_in), .pixel_valid_in(pixel_valid_in),
    .patch_out(patch_out), .patch_valid_out(patch_valid_out), .patch_ready_in(patch_ready_in),
    .patch_x_out(patch_x_out), .patch_y_out(patch_y_out), .busy_out(busy_out),
    .row_done_out(row_done_out)
  );

  always #5 clk_in = ~clk_in;

  // request seen at one edge is answered just after it, captured on the next edge
  always @(posedge clk_in) begin : buf_model
    logic        bv;
    logic [10:0] bh;
    logic [9:0]  bvr;
    bv  = valid_read_out;
    bh  = read_hor_addr_out;
    bvr = read_ver_addr_out;
    #1;
    pixel_valid_in = bv | inj_valid;
    pixel_read_in  = inj_valid ? inj_data : ({bvr[7:0], 8'h00} | {5'b0, bh});
  end

  function automatic logic [255:0] exp_patch(input int row, input int x);
    logic [255:0] p;
    p = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        p[(4*r+c)*16 +: 16] = 16'(((row + r) << 8) | (x + c));
    return p;
  endfunction

  function automatic exp_t mk(input int row, input int x);
    exp_t e;
    e.data = exp_patch(row, x);
    e.x = 7'(x);
    e.y = 10'(row);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #3;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    checks++;
    if (valid_read_out !== 1'b0 || patch_valid_out !== 1'b0 || busy_out !== 1'b0 || row_done_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl rd=%b pv=%b busy=%b done=%b expected all 0",
               valid_read_out, patch_valid_out, busy_out, row_done_out);
    end
    checks++;
    if (patch_out !== '0 || patch_x_out !== '0 || patch_y_out !== '0 ||
        read_hor_addr_out !== '0 || read_ver_addr_out !== '0) begin
      failures++;
      $display("FAIL reset_data x=%0d y=%0d hor=%0d ver=%0d patch=%h expected all 0",
               patch_x_out, patch_y_out, read_hor_addr_out, read_ver_addr_out, patch_out);
    end
    rst_in = 1'b0;
    tick();
    checks++;
    if (busy_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b expected 0", busy_out);
    end
  endtask

  task automatic test_full_fetch();
    int cnt;
    int first_rd;
    exp_t e;
    patch_row_in = 10'd4;
    start_in = 1'b1;
    sb.push_back(mk(4, 0));
    tick();
    start_in = 1'b0;
    cnt = 0;
    first_rd = -1;
    reads_full = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (valid_read_out) begin
        reads_full++;
        if (first_rd < 0) first_rd = cnt;
      end
      if (patch_valid_out) break;
    end
    checks++;
    if (cnt !== 19 || patch_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL full_latency got %0d cycles valid=%b expected 19 valid=1", cnt, patch_valid_out);
    end
    checks++;
    if (first_rd !== 1 || reads_full !== 16) begin
      failures++;
      $display("FAIL full_reads first=%0d count=%0d expected first=1 count=16", first_rd, reads_full);
    end
    checks++;
    e = sb[0];
    if (patch_out !== e.data || patch_x_out !== e.x || patch_y_out !== e.y) begin
      failures++;
      $display("FAIL full_patch x=%0d y=%0d patch=%h expected x=%0d y=%0d patch=%h",
               patch_x_out, patch_y_out, patch_out, e.x, e.y, e.data);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (patch_valid_out !== 1'b1 || patch_out !== exp_patch(4, 0) || patch_x_out !== 7'd0 ||
          patch_y_out !== 10'd4 || valid_read_out !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d pv=%b x=%0d y=%0d rd=%b patch=%h expected pv=1 x=0 y=4 rd=0 patch=%h",
                 i, patch_valid_out, patch_x_out, patch_y_out, valid_read_out, patch_out, exp_patch(4, 0));
      end
    end
  endtask

  task automatic test_busy_start();
    start_in = 1'b1;
    patch_row_in = 10'd9;
    inj_valid = 1'b1;
    inj_data = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy_out !== 1'b1 || patch_valid_out !== 1'b1 || patch_out !== exp_patch(4, 0) ||
          patch_y_out !== 10'd4 || valid_read_out !== 1'b0) begin
        failures++;
        $display("FAIL busy_start cyc=%0d busy=%b pv=%b y=%0d rd=%b patch=%h expected busy=1 pv=1 y=4 rd=0 patch=%h",
                 i, busy_out, patch_valid_out, patch_y_out, valid_read_out, patch_out, exp_patch(4, 0));
      end
    end
    start_in = 1'b0;
    inj_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_full_row();
    int n_hs, n_done, done_x, last_x, reads_row, cyc, hs_edge, t_inc;
    exp_t e;
    n_hs = 0; n_done = 0; done_x = -1; last_x = -1; reads_row = 0;
    cyc = 0; hs_edge = -1; t_inc = -1;
    patch_ready_in = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (patch_valid_out && patch_ready_in) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL row_patch scoreboard empty at x=%0d", patch_x_out);
        end else begin
          e = sb.pop_front();
          if (patch_out !== e.data || patch_x_out !== e.x || patch_y_out !== e.y) begin
            failures++;
            $display("FAIL row_patch x=%0d y=%0d patch=%h expected x=%0d y=%0d patch=%h",
                     patch_x_out, patch_y_out, patch_out, e.x, e.y, e.data);
          end
          if (int'(e.x) < LAST_X) sb.push_back(mk(4, int'(e.x) + 1));
        end
        n_hs++;
        last_x = int'(patch_x_out);
        if (n_hs == 1) hs_edge = cyc + 1;
      end
      tick();
      cyc++;
      if (valid_read_out) reads_row++;
      if (row_done_out) begin
        n_done++;
        done_x = last_x;
      end
      if (n_hs == 1 && t_inc < 0 && patch_valid_out) t_inc = cyc - hs_edge;
      if (!busy_out) break;
    end
    patch_ready_in = 1'b0;
    checks++;
    if (t_inc !== 7) begin
      failures++;
      $display("FAIL incr_latency got %0d expected 7", t_inc);
    end
    checks++;
    if (n_hs !== 128 || busy_out !== 1'b0) begin
      failures++;
      $display("FAIL row_count patches=%0d busy=%b expected 128 busy=0", n_hs, busy_out);
    end
    checks++;
    if (n_done !== 1 || done_x !== LAST_X) begin
      failures++;
      $display("FAIL row_done pulses=%0d at_x=%0d expected 1 at_x=127", n_done, done_x);
    end
    checks++;
    if (reads_full + reads_row !== 16 + 127 * 4) begin
      failures++;
      $display("FAIL row_reads got %0d expected %0d", reads_full + reads_row, 16 + 127 * 4);
    end
  endtask

  task automatic test_idle_ignore();
    inj_valid = 1'b1;
    inj_data = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy_out !== 1'b0 || patch_valid_out !== 1'b0 || valid_read_out !== 1'b0 ||
          patch_out !== exp_patch(4, LAST_X) || patch_x_out !== 7'(LAST_X)) begin
        failures++;
        $display("FAIL idle_ignore cyc=%0d busy=%b pv=%b rd=%b x=%0d patch=%h expected busy=0 pv=0 rd=0 x=127 patch=%h",
                 i, busy_out, patch_valid_out, valid_read_out, patch_x_out, patch_out, exp_patch(4, LAST_X));
      end
    end
    inj_valid = 1'b0;
    tick();
    frame_rst_in = 1'b1;
    start_in = 1'b1;
    tick();
    frame_rst_in = 1'b0;
    start_in = 1'b0;
    tick();
    checks++;
    if (busy_out !== 1'b0 || valid_read_out !== 1'b0) begin
      failures++;
      $display("FAIL frame_beats_start busy=%b rd=%b expected busy=0 rd=0", busy_out, valid_read_out);
    end
  endtask

  task automatic test_frame_abort();
    int cnt;
    exp_t e;
    sb.delete();
    patch_row_in = 10'd4;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (9) tick();
    frame_rst_in = 1'b1;
    tick();
    frame_rst_in = 1'b0;
    checks++;
    if (valid_read_out !== 1'b0 || patch_valid_out !== 1'b0 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_enter rd=%b pv=%b busy=%b expected rd=0 pv=0 busy=1",
               valid_read_out, patch_valid_out, busy_out);
    end
    tick();
    checks++;
    if (busy_out !== 1'b1 || valid_read_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_drain busy=%b rd=%b expected busy=1 rd=0", busy_out, valid_read_out);
    end
    tick();
    checks++;
    if (busy_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b expected 0", busy_out);
    end
    patch_row_in = 10'd8;
    start_in = 1'b1;
    sb.push_back(mk(8, 0));
    tick();
    start_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (patch_valid_out) break;
    end
    checks++;
    if (cnt !== 19 || patch_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL restart_latency got %0d cycles valid=%b expected 19 valid=1", cnt, patch_valid_out);
    end
    checks++;
    e = sb.pop_front();
    if (patch_out !== e.data || patch_x_out !== e.x || patch_y_out !== e.y) begin
      failures++;
      $display("FAIL restart_patch x=%0d y=%0d patch=%h expected x=%0d y=%0d patch=%h",
               patch_x_out, patch_y_out, patch_out, e.x, e.y, e.data);
    end
    patch_ready_in = 1'b1;
    tick();
    patch_ready_in = 1'b0;
    frame_rst_in = 1'b1;
    tick();
    frame_rst_in = 1'b0;
    tick();
    tick();
    checks++;
    if (busy_out !== 1'b0 || valid_read_out !== 1'b0) begin
      failures++;
      $display("FAIL abort_from_incr busy=%b rd=%b expected busy=0 rd=0", busy_out, valid_read_out);
    end
    sb.delete();
  endtask

  task automatic test_async_reset();
    patch_row_in = 10'd4;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (5) tick();
    checks++;
    if (valid_read_out !== 1'b1 || busy_out !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_fill rd=%b busy=%b expected rd=1 busy=1", valid_read_out, busy_out);
    end
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (valid_read_out !== 1'b0 || patch_valid_out !== 1'b0 || busy_out !== 1'b0 || row_done_out !== 1'b0 ||
        patch_out !== '0 || patch_x_out !== '0 || patch_y_out !== '0 ||
        read_hor_addr_out !== '0 || read_ver_addr_out !== '0) begin
      failures++;
      $display("FAIL async_reset rd=%b pv=%b busy=%b x=%0d y=%0d hor=%0d ver=%0d patch=%h expected all 0",
               valid_read_out, patch_valid_out, busy_out, patch_x_out, patch_y_out,
               read_hor_addr_out, read_ver_addr_out, patch_out);
    end
    tick();
    rst_in = 1'b0;
    tick();
    checks++;
    if (busy_out !== 1'b0 || valid_read_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset busy=%b rd=%b expected busy=0 rd=0", busy_out, valid_read_out);
    end
  endtask

  initial begin
    test_reset();
    test_full_fetch();
    test_hold();
    test_busy_start();
    test_full_row();
    test_idle_ignore();
    test_frame_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
